// File: rtl/cutoff_inverse.sv
//------------------------------------------------------------------------------
// Module   : cutoff_inverse
// Purpose  : Bisection inverse of the Q16.16 smooth cutoff
//            fc = (1-(1-x)^4)^2. Finds the smallest x in 0..1.0 whose cutoff
//            value reaches the target, then returns r = rc - x*dr.
//            The f(x) datapath matches the forward cutoff block bit for bit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cutoff_inverse (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_in_valid,
   output logic        o_in_ready,
   input  logic [31:0] i_rc,
   input  logic [31:0] i_dr,
   input  logic [31:0] i_fc_target,
   output logic        o_out_valid,
   input  logic        i_out_ready,
   output logic [31:0] o_r_out,
   output logic [31:0] o_x_out,
   output logic        o_sat
);

   localparam int          Q      = 16;
   localparam logic [31:0] QONE   = 32'h0001_0000;
   localparam logic [4:0]  N_ITER = 5'd17;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_SQ   = 3'd1;
   localparam logic [2:0] S_CMP  = 3'd2;
   localparam logic [2:0] S_FIN  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]  r_state;
   logic [31:0] r_rc;
   logic [31:0] r_dr;
   logic [31:0] r_tgt;
   logic [16:0] r_lo;
   logic [16:0] r_hi;
   logic [4:0]  r_it;
   logic [31:0] r_t2q;
   logic [31:0] r_r_out;
   logic [31:0] r_x_out;
   logic        r_sat;
   logic        r_out_valid;

   logic [16:0]        w_mid;
   logic signed [31:0] w_t;
   logic signed [63:0] w_tt;
   logic [31:0]        w_t2q_next;
   logic signed [63:0] w_t4q_p;
   logic [31:0]        w_t4q;
   logic signed [31:0] w_omt4;
   logic signed [63:0] w_f_p;
   logic signed [31:0] w_f;
   logic               w_ge;
   logic signed [63:0] w_xd_p;
   logic [31:0]        w_xd;
   logic [31:0]        w_r;

   // Bisection midpoint; lo/hi are stable across SQ and CMP so both share it
   assign w_mid      = 17'((18'(r_lo) + 18'(r_hi)) >> 1);

   // (1-x)^2 stage, registered into r_t2q during SQ
   assign w_t        = $signed(QONE - {15'd0, w_mid});
   assign w_tt       = w_t * w_t;
   assign w_t2q_next = 32'(w_tt >>> Q);

   // (1-x)^4, 1-(1-x)^4 and the final square, evaluated during CMP
   assign w_t4q_p    = $signed(r_t2q) * $signed(r_t2q);
   assign w_t4q      = 32'(w_t4q_p >>> Q);
   assign w_omt4     = $signed(QONE - w_t4q);
   assign w_f_p      = w_omt4 * w_omt4;
   assign w_f        = 32'(w_f_p >>> Q);
   assign w_ge       = (w_f >= $signed(r_tgt));

   // Radius from the final x code; subtraction wraps mod 2^32
   assign w_xd_p     = $signed({15'd0, r_lo}) * $signed(r_dr);
   assign w_xd       = 32'(w_xd_p >>> Q);
   assign w_r        = r_rc - w_xd;

   assign o_in_ready  = (r_state == S_IDLE);
   assign o_out_valid = r_out_valid;
   assign o_r_out     = r_r_out;
   assign o_x_out     = r_x_out;
   assign o_sat       = r_sat;

   // Control FSM, bisection state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_rc        <= 32'd0;
         r_dr        <= 32'd0;
         r_tgt       <= 32'd0;
         r_lo        <= 17'd0;
         r_hi        <= 17'd0;
         r_it        <= 5'd0;
         r_t2q       <= 32'd0;
         r_r_out     <= 32'd0;
         r_x_out     <= 32'd0;
         r_sat       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_in_valid) begin
                  r_rc    <= i_rc;
                  r_dr    <= i_dr;
                  r_tgt   <= i_fc_target;
                  r_lo    <= 17'd0;
                  r_hi    <= 17'h1_0000;
                  r_it    <= 5'd0;
                  r_sat   <= ($signed(i_fc_target) > $signed(QONE));
                  r_state <= S_SQ;
               end
            end
            S_SQ: begin
               r_t2q   <= w_t2q_next;
               r_state <= S_CMP;
            end
            S_CMP: begin
               // Once the interval has collapsed, lo must not step past hi
               // (this matters when the target is unreachable)
               if (r_lo != r_hi) begin
                  if (w_ge) begin
                     r_hi <= w_mid;
                  end else begin
                     r_lo <= w_mid + 17'd1;
                  end
               end
               r_it <= r_it + 5'd1;
               if (r_it == N_ITER - 5'd1) begin
                  r_state <= S_FIN;
               end else begin
                  r_state <= S_SQ;
               end
            end
            S_FIN: begin
               r_x_out     <= {15'd0, r_lo};
               r_r_out     <= w_r;
               r_out_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               if (i_out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cutoff_inverse.sv
//------------------------------------------------------------------------------
// Module   : tb_cutoff_inverse
// Purpose  : Self-checking bench for cutoff_inverse: directed vector table,
//            backpressure / busy-request sequence, mid-operation reset and a
//            random sweep checked against an independent forward model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cutoff_inverse;

   logic        clk;
   logic        rst_n;
   logic        i_in_valid;
   logic        o_in_ready;
   logic [31:0] i_rc;
   logic [31:0] i_dr;
   logic [31:0] i_fc_target;
   logic        o_out_valid;
   logic        i_out_ready;
   logic [31:0] o_r_out;
   logic [31:0] o_x_out;
   logic        o_sat;

   int n_cmp;
   int n_fail;

   cutoff_inverse dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_in_valid  (i_in_valid),
      .o_in_ready  (o_in_ready),
      .i_rc        (i_rc),
      .i_dr        (i_dr),
      .i_fc_target (i_fc_target),
      .o_out_valid (o_out_valid),
      .i_out_ready (i_out_ready),
      .o_r_out     (o_r_out),
      .o_x_out     (o_x_out),
      .o_sat       (o_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rc;
      logic [31:0] dr;
      logic [31:0] tgt;
      logic [31:0] ex;
      logic [31:0] er;
      logic        es;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Forward cutoff value for a normalized distance code x (0..65536)
   function automatic longint fmodel(input longint x);
      longint t, t2, t4, om;
      t  = 65536 - x;
      t2 = (t * t) >>> 16;
      t4 = (t2 * t2) >>> 16;
      om = 65536 - t4;
      return (om * om) >>> 16;
   endfunction

   // Issue one request and wait (bounded) for out_valid; lat counts edges after accept
   task automatic do_req(input logic [31:0] rc, input logic [31:0] dr,
                         input logic [31:0] tgt, output int lat);
      @(negedge clk);
      chk("pre_in_ready", 32'(o_in_ready), 32'd1);
      i_rc        = rc;
      i_dr        = dr;
      i_fc_target = tgt;
      i_in_valid  = 1'b1;
      @(posedge clk);
      #1;
      i_in_valid = 1'b0;
      lat = 0;
      while (o_out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   // Consume the result and confirm the block returns to idle
   task automatic handshake();
      @(negedge clk);
      i_out_ready = 1'b1;
      @(posedge clk);
      #1;
      i_out_ready = 1'b0;
      chk("hs_out_valid", 32'(o_out_valid), 32'd0);
      chk("hs_in_ready", 32'(o_in_ready), 32'd1);
   endtask

   initial begin
      int     lat;
      longint tgt_s, x_s, dr_s, fx, fxm1;
      logic [31:0] rc_r, dr_r, tgt_r, er;

      n_cmp       = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      i_in_valid  = 1'b0;
      i_out_ready = 1'b0;
      i_rc        = 32'd0;
      i_dr        = 32'd0;
      i_fc_target = 32'd0;

      vecs[0] = '{32'h0006_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0000, 32'h0006_0000, 1'b0};
      vecs[1] = '{32'h0006_0000, 32'h0001_0000, 32'h0001_0000, 32'h0000_F001, 32'h0005_0FFF, 1'b0};
      vecs[2] = '{32'h0006_0000, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 32'h0005_0000, 1'b1};
      vecs[3] = '{32'h0006_0000, 32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0006_0000, 1'b0};
      vecs[4] = '{32'h0003_0000, 32'h0000_0000, 32'h0001_0000, 32'h0000_F001, 32'h0003_0000, 1'b0};
      vecs[5] = '{32'h0002_0000, 32'h0000_8000, 32'h0001_0000, 32'h0000_F001, 32'h0001_8800, 1'b0};
      vecs[6] = '{32'h0004_0000, 32'h0001_0000, 32'h8000_0000, 32'h0000_0000, 32'h0004_0000, 1'b0};
      vecs[7] = '{32'h0004_0000, 32'h0001_0000, 32'h7FFF_FFFF, 32'h0001_0000, 32'h0003_0000, 1'b1};
      vecs[8] = '{32'h0001_0000, 32'hFFFF_0000, 32'h0001_0001, 32'h0001_0000, 32'h0002_0000, 1'b1};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(o_in_ready), 32'd1);
      chk("rst_out_valid", 32'(o_out_valid), 32'd0);
      chk("rst_r_out", o_r_out, 32'd0);
      chk("rst_x_out", o_x_out, 32'd0);
      chk("rst_sat", 32'(o_sat), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vector table
      for (int i = 0; i < 9; i++) begin
         do_req(vecs[i].rc, vecs[i].dr, vecs[i].tgt, lat);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'd35);
         chk($sformatf("v%0d_x_out", i), o_x_out, vecs[i].ex);
         chk($sformatf("v%0d_r_out", i), o_r_out, vecs[i].er);
         chk($sformatf("v%0d_sat", i), 32'(o_sat), 32'(vecs[i].es));
         handshake();
      end

      // Busy request ignored, then backpressure in DONE
      @(negedge clk);
      i_rc        = 32'h0006_0000;
      i_dr        = 32'h0001_0000;
      i_fc_target = 32'h0001_0000;
      i_in_valid  = 1'b1;
      @(posedge clk);
      #1;
      i_in_valid = 1'b0;
      lat = 0;
      while (o_out_valid !== 1'b1 && lat < 100) begin
         if (lat == 4) begin
            @(negedge clk);
            chk("busy_in_ready", 32'(o_in_ready), 32'd0);
            i_rc        = 32'h1234_0000;
            i_fc_target = 32'h0000_0000;
            i_in_valid  = 1'b1;
         end
         @(posedge clk);
         #1;
         i_in_valid = 1'b0;
         lat++;
      end
      chk("busy_latency", 32'(lat), 32'd35);
      chk("busy_x_out", o_x_out, 32'h0000_F001);
      chk("busy_r_out", o_r_out, 32'h0005_0FFF);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         chk("bp_out_valid", 32'(o_out_valid), 32'd1);
         chk("bp_in_ready", 32'(o_in_ready), 32'd0);
         chk("bp_x_out", o_x_out, 32'h0000_F001);
         chk("bp_r_out", o_r_out, 32'h0005_0FFF);
      end
      handshake();

      // Reset 10 cycles into an operation
      @(negedge clk);
      i_rc        = 32'h0006_0000;
      i_dr        = 32'h0001_0000;
      i_fc_target = 32'h0000_0000;
      i_in_valid  = 1'b1;
      @(posedge clk);
      #1;
      i_in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mrst_out_valid", 32'(o_out_valid), 32'd0);
      chk("mrst_r_out", o_r_out, 32'd0);
      chk("mrst_in_ready", 32'(o_in_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      do_req(32'h0006_0000, 32'h0001_0000, 32'h0001_0000, lat);
      chk("mrst_latency", 32'(lat), 32'd35);
      chk("mrst_x_out", o_x_out, 32'h0000_F001);
      chk("mrst_r_out2", o_r_out, 32'h0005_0FFF);
      handshake();

      // Random sweep against the forward model
      for (int n = 0; n < 400; n++) begin
         tgt_s = longint'($urandom_range(32'h0001_0200, 0)) - 256;
         tgt_r = 32'(tgt_s);
         rc_r  = $urandom;
         dr_r  = $urandom_range(32'h0004_0000, 32'h0000_1000);
         do_req(rc_r, dr_r, tgt_r, lat);
         chk("rnd_latency", 32'(lat), 32'd35);
         x_s  = longint'(o_x_out);
         dr_s = longint'(dr_r);
         if (tgt_s > 65536) begin
            chk("rnd_x_unreach", o_x_out, 32'h0001_0000);
         end else begin
            fx = fmodel(x_s);
            chk("rnd_f_reaches", 32'(fx >= tgt_s), 32'd1);
            fxm1 = (x_s == 0) ? -1 : fmodel(x_s - 1);
            chk("rnd_x_smallest", 32'((x_s == 0) || (fxm1 < tgt_s)), 32'd1);
         end
         er = rc_r - 32'((x_s * dr_s) >>> 16);
         chk("rnd_r_out", o_r_out, er);
         chk("rnd_sat", 32'(o_sat), 32'(tgt_s > 65536));
         handshake();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
